// File: rtl/seq_divider_if.sv
// Handshake and result bundle for seq_divider: the requester drives start/operands,
// the divider returns busy/done and the held results.
interface seq_divider_if #(
  parameter int unsigned WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, results held
// until the next accepted start, divide-by-zero answered at the accept edge.
module seq_divider #(
  parameter int unsigned WIDTH = 4
) (
  input logic          clk,
  input logic          rst_n,
  seq_divider_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] q, q_next;
  logic [WIDTH:0]   r, r_next;
  logic [WIDTH-1:0] d, d_next;
  logic [CW-1:0]    cnt, cnt_next;
  logic [WIDTH-1:0] quo, quo_next;
  logic [WIDTH-1:0] rem, rem_next;
  logic             done, done_next;
  logic             dbz, dbz_next;
  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   trial;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q    <= '0;
      r    <= '0;
      d    <= '0;
      cnt  <= '0;
      quo  <= '0;
      rem  <= '0;
      done <= 1'b0;
      dbz  <= 1'b0;
    end else begin
      q    <= q_next;
      r    <= r_next;
      d    <= d_next;
      cnt  <= cnt_next;
      quo  <= quo_next;
      rem  <= rem_next;
      done <= done_next;
      dbz  <= dbz_next;
    end
  end

  always_comb begin
    state_next = state;
    q_next     = q;
    r_next     = r;
    d_next     = d;
    cnt_next   = cnt;
    quo_next   = quo;
    rem_next   = rem;
    dbz_next   = dbz;
    done_next  = 1'b0;
    r_shift    = {r[WIDTH-1:0], q[WIDTH-1]};
    trial      = r_shift - {1'b0, d};

    case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.divisor == '0) begin
            // Zero divisor completes in place; no iterations are started.
            quo_next  = '1;
            rem_next  = bus.dividend;
            dbz_next  = 1'b1;
            done_next = 1'b1;
          end else begin
            q_next     = bus.dividend;
            r_next     = '0;
            d_next     = bus.divisor;
            cnt_next   = CW'(WIDTH);
            quo_next   = '0;
            rem_next   = '0;
            dbz_next   = 1'b0;
            state_next = RUN;
          end
        end
      end
      RUN: begin
        if (!trial[WIDTH]) begin
          r_next = trial;
          q_next = {q[WIDTH-2:0], 1'b1};
        end else begin
          r_next = r_shift;
          q_next = {q[WIDTH-2:0], 1'b0};
        end
        cnt_next = cnt - 1'b1;
        if (cnt == CW'(1)) begin
          quo_next   = q_next;
          rem_next   = r_next[WIDTH-1:0];
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.busy        = (state == RUN);
  assign bus.done        = done;
  assign bus.quotient    = quo;
  assign bus.remainder   = rem;
  assign bus.div_by_zero = dbz;
endmodule
